// File: rtl/mbc1_cartridge_if.sv
// mbc1_cartridge_if: CPU peripheral bus between the MMU and the cartridge
// master: drives addr, wdata, read_en, write_en; receives combinational rdata
// slave : the cartridge side of the same signals
interface mbc1_cartridge_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        read_en;
  logic        write_en;
  modport master (output addr, wdata, read_en, write_en, input rdata);
  modport slave  (input addr, wdata, read_en, write_en, output rdata);
endinterface

// File: rtl/mbc1_cartridge.sv
// mbc1_cartridge: MBC1-style bank controller with banked ROM and optional banked RAM
// Ports: clk, reset (async, active-high); bus (CPU bus, slave modport);
//   load_en/load_addr/load_data (side-band ROM image loader);
//   bank_lo/bank_hi/ram_enabled (debug views of BANK1, BANK2, RAM enable).
// Macro MBC1_RAM_EN: instantiates RAM_BANKS x 8 KiB external RAM at 0xA000-0xBFFF;
//   without it that window reads 8'hFF and swallows writes.
module mbc1_cartridge #(
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  mbc1_cartridge_if.slave                 bus,
  input  logic                            load_en,
  input  logic [$clog2(ROM_BANKS)+13:0]   load_addr,
  input  logic [7:0]                      load_data,
  output logic [4:0]                      bank_lo,
  output logic [1:0]                      bank_hi,
  output logic                            ram_enabled
);
  localparam int RB = $clog2(ROM_BANKS);
  logic mode;
  logic cpu_wr;
  logic ram_sel;
  logic [6:0] rom_bank;
  logic [RB+13:0] rom_idx;
  logic [7:0] ram_data;
  logic [7:0] rom [ROM_BANKS*16384];
  assign cpu_wr = bus.write_en && !load_en;
  assign ram_sel = bus.addr[15:13] == 3'b101;
  // Lower window only follows BANK2 in mode 1; masking to a power of two is a truncation.
  assign rom_bank = bus.addr[14] ? {bank_hi, bank_lo} : (mode ? {bank_hi, 5'd0} : 7'd0);
  assign rom_idx = {rom_bank[RB-1:0], bus.addr[13:0]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ram_enabled <= 1'b0;
      bank_lo <= 5'd1;
      bank_hi <= 2'd0;
      mode <= 1'b0;
    end else if (cpu_wr && !bus.addr[15])
      case (bus.addr[14:13])
        2'd0: ram_enabled <= bus.wdata[3:0] == 4'hA;
        2'd1: bank_lo <= bus.wdata[4:0] == 5'd0 ? 5'd1 : bus.wdata[4:0];
        2'd2: bank_hi <= bus.wdata[1:0];
        default: mode <= bus.wdata[0];
      endcase
  // Arrays are deliberately outside the reset so loads survive (and occur on) reset edges.
  always_ff @(posedge clk)
    if (load_en) rom[load_addr] <= load_data;
`ifdef MBC1_RAM_EN
  localparam int AB = RAM_BANKS > 1 ? $clog2(RAM_BANKS) : 1;
  logic [7:0] ram [RAM_BANKS*8192];
  logic [AB+12:0] ram_idx;
  assign ram_idx = {AB'(mode ? bank_hi & 2'(RAM_BANKS-1) : 2'd0), bus.addr[12:0]};
  assign ram_data = ram_enabled ? ram[ram_idx] : 8'hFF;
  always_ff @(posedge clk)
    if (cpu_wr && ram_sel && ram_enabled) ram[ram_idx] <= bus.wdata;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.wdata[7:5], RAM_BANKS[0]};
  assign ram_data = 8'hFF;
`endif
  assign bus.rdata = (!bus.read_en || load_en) ? 8'hFF :
                     !bus.addr[15] ? rom[rom_idx] :
                     ram_sel ? ram_data : 8'hFF;
endmodule

// File: tb/tb_mbc1_cartridge.sv
// tb_mbc1_cartridge: directed self-checking bench for mbc1_cartridge (64-bank and 8-bank builds)
module tb_mbc1_cartridge;
  logic clk = 0;
  logic reset = 1;
  logic le_a = 0, le_b = 0;
  logic [19:0] la_a = '0;
  logic [16:0] la_b = '0;
  logic [7:0] ld_a = '0, ld_b = '0;
  logic [4:0] blo_a, blo_b;
  logic [1:0] bhi_a, bhi_b;
  logic re_a, re_b;
  int total = 0;
  int fails = 0;
  mbc1_cartridge_if bus_a();
  mbc1_cartridge_if bus_b();
  mbc1_cartridge #(.ROM_BANKS(64), .RAM_BANKS(4)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a), .load_en(le_a), .load_addr(la_a),
    .load_data(ld_a), .bank_lo(blo_a), .bank_hi(bhi_a), .ram_enabled(re_a));
  mbc1_cartridge #(.ROM_BANKS(8), .RAM_BANKS(4)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b), .load_en(le_b), .load_addr(la_b),
    .load_data(ld_b), .bank_lo(blo_b), .bank_hi(bhi_b), .ram_enabled(re_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input bit s, input logic [15:0] a, input logic [7:0] d);
    if (s) begin
      bus_b.addr = a; bus_b.wdata = d; bus_b.write_en = 1;
    end else begin
      bus_a.addr = a; bus_a.wdata = d; bus_a.write_en = 1;
    end
    @(posedge clk); #1;
    bus_a.write_en = 0; bus_b.write_en = 0;
  endtask
  task automatic rd(input bit s, input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    if (s) begin
      bus_b.addr = a; bus_b.read_en = 1; #1; d = bus_b.rdata;
    end else begin
      bus_a.addr = a; bus_a.read_en = 1; #1; d = bus_a.rdata;
    end
    bus_a.read_en = 0; bus_b.read_en = 0;
    chk(tag, d, exp);
  endtask
  task automatic ld(input bit s, input logic [19:0] a, input logic [7:0] d);
    if (s) begin
      le_b = 1; la_b = a[16:0]; ld_b = d;
    end else begin
      le_a = 1; la_a = a; ld_a = d;
    end
    @(posedge clk); #1;
    le_a = 0; le_b = 0;
  endtask
  initial begin
    bus_a.addr = '0; bus_a.wdata = '0; bus_a.read_en = 0; bus_a.write_en = 0;
    bus_b.addr = '0; bus_b.wdata = '0; bus_b.read_en = 0; bus_b.write_en = 0;
    #12 reset = 0;
    chk("rst_bank_lo", 8'(blo_a), 8'd1);
    chk("rst_bank_hi", 8'(bhi_a), 8'd0);
    chk("rst_ram_en", 8'(re_a), 8'd0);
    for (int b = 0; b < 64; b++) ld(0, 20'(b) << 14, 8'(b));
    ld(0, 20'h17FFF, 8'hA5);
    for (int b = 0; b < 8; b++) ld(1, 20'(b) << 14, 8'h80 | 8'(b));
    // loader active: reads blocked, CPU writes ignored
    le_a = 1; la_a = 20'hFC001; ld_a = 8'h77;
    bus_a.addr = 16'h4000; bus_a.read_en = 1; #1;
    chk("load_blocks_read", bus_a.rdata, 8'hFF);
    bus_a.read_en = 0;
    wr(0, 16'h2000, 8'h07);
    le_a = 0;
    chk("load_blocks_write", 8'(blo_a), 8'd1);
    rd(0, "rom_bank1", 16'h4000, 8'h01);
    wr(0, 16'h2000, 8'h00);
    chk("bank1_zero", 8'(blo_a), 8'd1);
    rd(0, "rom_bank1_zero", 16'h4000, 8'h01);
    wr(0, 16'h2000, 8'h1F);
    rd(0, "rom_bank1f", 16'h4000, 8'h1F);
    wr(0, 16'h2000, 8'h20);
    chk("bank1_0x20", 8'(blo_a), 8'd1);
    wr(0, 16'h4000, 8'h01);
    wr(0, 16'h2000, 8'h05);
    chk("bank2_reg", 8'(bhi_a), 8'd1);
    rd(0, "rom_bank25", 16'h4000, 8'h25);
    rd(0, "rom_lo_mode0", 16'h0000, 8'h00);
    wr(0, 16'h6000, 8'h01);
    rd(0, "rom_lo_mode1", 16'h0000, 8'h20);
    wr(0, 16'h6000, 8'h00);
    rd(0, "rom_lo_mode0b", 16'h0000, 8'h00);
    wr(0, 16'h4000, 8'h00);
    rd(0, "rom_top_byte", 16'h7FFF, 8'hA5);
    bus_a.addr = 16'h4000; #1;
    chk("read_en_low", bus_a.rdata, 8'hFF);
    rd(0, "unmapped_8000", 16'h8000, 8'hFF);
    rd(0, "unmapped_c000", 16'hC000, 8'hFF);
    wr(0, 16'h0000, 8'h1A);
    chk("ram_en_1a", 8'(re_a), 8'd1);
    wr(0, 16'h1FFF, 8'h0B);
    chk("ram_en_0b", 8'(re_a), 8'd0);
`ifdef MBC1_RAM_EN
    wr(0, 16'hA000, 8'h55);
    rd(0, "ram_disabled", 16'hA000, 8'hFF);
    wr(0, 16'h0000, 8'h0A);
    wr(0, 16'hA000, 8'h55);
    rd(0, "ram_55", 16'hA000, 8'h55);
    wr(0, 16'hA001, 8'h11);
    bus_a.addr = 16'hA001; bus_a.wdata = 8'h66; bus_a.write_en = 1; bus_a.read_en = 1; #1;
    chk("ram_rw_old", bus_a.rdata, 8'h11);
    @(posedge clk); #1;
    bus_a.write_en = 0;
    chk("ram_rw_new", bus_a.rdata, 8'h66);
    bus_a.read_en = 0;
    wr(0, 16'h6000, 8'h01);
    wr(0, 16'h4000, 8'h02);
    wr(0, 16'hA000, 8'h77);
    rd(0, "ram_bank2", 16'hA000, 8'h77);
    wr(0, 16'h4000, 8'h00);
    rd(0, "ram_bank0", 16'hA000, 8'h55);
    wr(0, 16'h4000, 8'h02);
    wr(0, 16'h6000, 8'h00);
    rd(0, "ram_mode0", 16'hA000, 8'h55);
    wr(0, 16'h4000, 8'h00);
    wr(0, 16'h0000, 8'h00);
    rd(0, "ram_off", 16'hA000, 8'hFF);
`else
    wr(0, 16'h0000, 8'h0A);
    wr(0, 16'hA000, 8'h55);
    rd(0, "no_ram", 16'hA000, 8'hFF);
    wr(0, 16'h0000, 8'h00);
`endif
    wr(1, 16'h2000, 8'h0B);
    rd(1, "mask8_bank", 16'h4000, 8'h83);
    wr(1, 16'h4000, 8'h03);
    rd(1, "rom_unchanged", 16'h0000, 8'h80);
    rd(1, "mask8_bank2", 16'h4000, 8'h83);
    wr(0, 16'h2000, 8'h05);
    wr(0, 16'h4000, 8'h01);
    wr(0, 16'h6000, 8'h01);
    wr(0, 16'h0000, 8'h0A);
    @(negedge clk);
    reset = 1; #1;
    chk("async_bank_lo", 8'(blo_a), 8'd1);
    chk("async_bank_hi", 8'(bhi_a), 8'd0);
    chk("async_ram_en", 8'(re_a), 8'd0);
    ld(0, 20'h08001, 8'h3C);
    @(negedge clk);
    reset = 0;
    rd(0, "post_rst_bank1", 16'h4000, 8'h01);
    rd(0, "post_rst_lo", 16'h0000, 8'h00);
    wr(0, 16'h2000, 8'h02);
    rd(0, "load_in_reset", 16'h4001, 8'h3C);
`ifdef MBC1_RAM_EN
    wr(0, 16'h0000, 8'h0A);
    rd(0, "ram_kept", 16'hA000, 8'h55);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
